// File: rtl/vc_test_pkg.sv
// Shared FSM state encoding and constants for the test check sink.
package vc_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // err_count holds at this value instead of wrapping back to zero
    localparam logic [31:0] c_err_sat = 32'hFFFF_FFFF;

endpackage

// File: rtl/vc_EnResetReg.sv
// Enabled register with synchronous active-high reset to a parameterised value.
module vc_EnResetReg #(
    parameter int                 p_nbits       = 1,
    parameter logic [p_nbits-1:0] p_reset_value = '0
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    // reset wins over enable; otherwise load d when enabled
    always_ff @(posedge clk) begin
        if (reset)
            q <= p_reset_value;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/vc_test_check_sink.sv
// Test sink: compares an incoming val/rdy stream against a preloaded
// expected-message memory and records mismatch statistics.
module vc_test_check_sink
    import vc_test_pkg::*;
#(
    parameter  int p_msg_nbits = 1,
    parameter  int p_num_msgs  = 1024,
    localparam int c_idx_nbits = $clog2(p_num_msgs) + 1
)(
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   go,
    input  logic [c_idx_nbits-1:0] num_msgs,

    input  logic                   ld_en,
    input  logic [c_idx_nbits-2:0] ld_idx,
    input  logic [p_msg_nbits-1:0] ld_msg,

    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_msg_nbits-1:0] in_msg,

    output logic                   done,
    output logic [31:0]            err_count,
    output logic [c_idx_nbits-1:0] first_err_idx,
    output logic [p_msg_nbits-1:0] first_err_got,
    output logic [p_msg_nbits-1:0] first_err_exp,
    output logic                   extra_msg
);

    localparam logic [c_idx_nbits-1:0] c_max_cnt = c_idx_nbits'(p_num_msgs);
    localparam logic [c_idx_nbits-1:0] c_one     = c_idx_nbits'(1);

    state_t                 state;
    logic [c_idx_nbits-1:0] count;
    logic [c_idx_nbits-1:0] idx;
    logic [p_msg_nbits-1:0] mem [p_num_msgs];

    logic                   start;
    logic                   fire;
    logic                   mismatch;
    logic                   last;
    logic [p_msg_nbits-1:0] exp_msg;
    logic [c_idx_nbits-1:0] num_clamped;
    logic                   idx_en;
    logic [c_idx_nbits-1:0] idx_d;
    logic                   err_en;
    logic [31:0]            err_d;

    // go is only honoured outside RUN
    assign start       = go && (state != RUN);
    assign fire        = in_val && in_rdy;
    assign exp_msg     = mem[idx[c_idx_nbits-2:0]];
    assign mismatch    = fire && (in_msg != exp_msg);
    assign last        = fire && (idx == count - c_one);
    assign num_clamped = (num_msgs > c_max_cnt) ? c_max_cnt : num_msgs;

    // idx: cleared on go, advanced on every accepted message
    assign idx_en = start || fire;
    assign idx_d  = start ? '0 : idx + c_one;

    vc_EnResetReg #(
        .p_nbits       (c_idx_nbits),
        .p_reset_value ('0)
    ) idx_reg (
        .clk   (clk),
        .reset (reset),
        .en    (idx_en),
        .d     (idx_d),
        .q     (idx)
    );

    // err_count: cleared on go, bumped on mismatch until saturated
    assign err_en = start || (mismatch && (err_count != c_err_sat));
    assign err_d  = start ? 32'd0 : err_count + 32'd1;

    vc_EnResetReg #(
        .p_nbits       (32),
        .p_reset_value (32'd0)
    ) err_reg (
        .clk   (clk),
        .reset (reset),
        .en    (err_en),
        .d     (err_d),
        .q     (err_count)
    );

    // expected memory: writable only outside RUN, never cleared by reset
    always_ff @(posedge clk) begin
        if (ld_en && (state != RUN))
            mem[ld_idx] <= ld_msg;
    end

    // control FSM with registered in_rdy/done and first-error record
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            in_rdy        <= 1'b0;
            done          <= 1'b0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            extra_msg     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        count         <= num_clamped;
                        first_err_idx <= '0;
                        first_err_got <= '0;
                        first_err_exp <= '0;
                        extra_msg     <= 1'b0;
                        if (num_clamped == '0) begin
                            state  <= DONE;
                            in_rdy <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            state  <= RUN;
                            in_rdy <= 1'b1;
                            done   <= 1'b0;
                        end
                    end else if ((state == DONE) && in_val) begin
                        extra_msg <= 1'b1;
                    end
                end
                RUN: begin
                    // err_count still zero means this is the first mismatch since go
                    if (mismatch && (err_count == 32'd0)) begin
                        first_err_idx <= idx;
                        first_err_got <= in_msg;
                        first_err_exp <= exp_msg;
                    end
                    if (last) begin
                        state  <= DONE;
                        in_rdy <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    in_rdy <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

    // control inputs must be known whenever the block is out of reset
    always @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown(in_val));
            assert (!$isunknown(go));
            assert (!$isunknown(num_msgs));
        end
    end

endmodule

// File: tb/tb_vc_test_check_sink.sv
// Scoreboard bench for vc_test_check_sink: the driver pushes the expected
// end-of-run record, the monitor pops and compares it when done rises.
module tb_vc_test_check_sink;

    localparam int NB = 8;
    localparam int NM = 16;
    localparam int IB = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic [IB-1:0] num_msgs = '0;
    logic          ld_en = 1'b0;
    logic [IB-2:0] ld_idx = '0;
    logic [NB-1:0] ld_msg = '0;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [NB-1:0] in_msg = '0;
    logic          done;
    logic [31:0]   err_count;
    logic [IB-1:0] first_err_idx;
    logic [NB-1:0] first_err_got;
    logic [NB-1:0] first_err_exp;
    logic          extra_msg;

    vc_test_check_sink #(.p_msg_nbits(NB), .p_num_msgs(NM)) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .num_msgs      (num_msgs),
        .ld_en         (ld_en),
        .ld_idx        (ld_idx),
        .ld_msg        (ld_msg),
        .in_val        (in_val),
        .in_rdy        (in_rdy),
        .in_msg        (in_msg),
        .done          (done),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .first_err_got (first_err_got),
        .first_err_exp (first_err_exp),
        .extra_msg     (extra_msg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] n;
        logic [31:0] errs;
        logic [31:0] fidx;
        logic [31:0] fgot;
        logic [31:0] fexp;
    } exp_t;

    exp_t        exp_q[$];
    logic [NB-1:0] ref_mem [NM];
    logic [NB-1:0] tx [32];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   last_ev = 0;
    int   fire_cnt = 0;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            fire_cnt = 0;
        end else begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("fires",         32'(fire_cnt),      e.n);
                    chk("err_count",     err_count,          e.errs);
                    chk("first_err_idx", 32'(first_err_idx), e.fidx);
                    chk("first_err_got", 32'(first_err_got), e.fgot);
                    chk("first_err_exp", 32'(first_err_exp), e.fexp);
                    chk("done_latency",  32'(cyc - last_ev), 32'd1);
                    chk("rdy_in_done",   32'(in_rdy),        32'd0);
                    chk("extra_at_done", 32'(extra_msg),     32'd0);
                end
            end
            if (go && !in_rdy) begin
                fire_cnt = 0;
                last_ev  = cyc;
            end
            if (in_val && in_rdy) begin
                fire_cnt++;
                last_ev = cyc;
            end
        end
        done_prev = done;
    end

    // ---------------- driver ----------------
    task automatic tick(input bit noise);
        @(posedge clk); #1;
        in_val = 1'b0;
        if (noise) begin
            ld_en  = 1'($urandom_range(1, 0));
            ld_idx = 4'($urandom_range(NM - 1, 0));
            ld_msg = 8'($urandom);
        end else begin
            ld_en = 1'b0;
        end
    endtask

    task automatic load(input int i, input logic [NB-1:0] v);
        ld_en = 1'b1; ld_idx = 4'(i); ld_msg = v;
        ref_mem[i] = v;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic send(input logic [NB-1:0] m, input int max_dly, input bit noise);
        int k;
        repeat ($urandom_range(max_dly, 0)) tick(noise);
        in_val = 1'b1;
        in_msg = m;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (in_rdy) break;
            k++;
            if (k > 50) begin
                chk("rdy_timeout", 32'd1, 32'd0);
                break;
            end
        end
        tick(noise);
    endtask

    // reference: count clamps to memory depth, compare tx[i] vs expected memory
    task automatic do_run(input int n, input int max_dly, input bit noise, input int abort_at);
        exp_t e;
        int   cnt;
        bit   got_err;
        cnt = (n > NM) ? NM : n;
        e = '0;
        e.n = 32'(cnt);
        got_err = 0;
        for (int i = 0; i < cnt; i++) begin
            if (tx[i] != ref_mem[i]) begin
                e.errs++;
                if (!got_err) begin
                    got_err = 1;
                    e.fidx = 32'(i);
                    e.fgot = 32'(tx[i]);
                    e.fexp = 32'(ref_mem[i]);
                end
            end
        end
        if (abort_at < 0) exp_q.push_back(e);
        num_msgs = IB'(n);
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            if (i == abort_at) break;
            send(tx[i], max_dly, noise);
        end
        in_val = 1'b0;
        ld_en  = 1'b0;
        if (abort_at < 0) begin
            int k;
            k = 0;
            while (!done) begin
                @(negedge clk);
                k++;
                if (k > 200) begin
                    chk("done_timeout", 32'd1, 32'd0);
                    break;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_done"},      32'(done),          32'd0);
        chk({tag, "_in_rdy"},    32'(in_rdy),        32'd0);
        chk({tag, "_err_count"}, err_count,          32'd0);
        chk({tag, "_fidx"},      32'(first_err_idx), 32'd0);
        chk({tag, "_fgot"},      32'(first_err_got), 32'd0);
        chk({tag, "_fexp"},      32'(first_err_exp), 32'd0);
        chk({tag, "_extra"},     32'(extra_msg),     32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_cleared("reset");

        // basic load and clean run, in_val held high
        for (int i = 0; i < NM; i++) load(i, 8'($urandom));
        load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
        do_run(4, 0, 0, -1);

        // two mismatches, restart from DONE
        tx[1] = 8'h99; tx[3] = 8'h55;
        do_run(4, 0, 0, -1);

        // traffic while DONE flags extra_msg without touching counters
        in_val = 1'b1;
        @(posedge clk); #1;
        in_val = 1'b0;
        chk("extra_set",     32'(extra_msg), 32'd1);
        chk("extra_rdy",     32'(in_rdy),    32'd0);
        chk("extra_done",    32'(done),      32'd1);
        chk("extra_errs",    err_count,      32'd2);

        // reset in the middle of a run with a mismatch already recorded
        tx[0] = 8'h77; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
        do_run(4, 0, 0, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_cleared("midrun_reset");

        // zero-length run from IDLE, then stray traffic
        do_run(0, 0, 0, -1);
        chk("zero_rdy", 32'(in_rdy), 32'd0);
        in_val = 1'b1;
        @(posedge clk); #1;
        in_val = 1'b0;
        chk("zero_extra", 32'(extra_msg), 32'd1);

        // memory survived reset: clean rerun from idx 0
        tx[0] = 8'h11;
        do_run(4, 2, 0, -1);

        // full depth with random upstream delay and ignored loads in RUN
        for (int i = 0; i < NM; i++) load(i, 8'($urandom));
        for (int i = 0; i < NM; i++) tx[i] = ref_mem[i];
        do_run(16, 5, 1, -1);
        do_run(16, 1, 0, -1);

        // random runs, including counts above memory depth
        for (int r = 0; r < 8; r++) begin
            int n;
            if (r % 3 == 0)
                for (int i = 0; i < NM; i++) load(i, 8'($urandom));
            n = $urandom_range(20, 1);
            for (int i = 0; i < NM; i++)
                tx[i] = ($urandom_range(3, 0) == 0) ? 8'($urandom) : ref_mem[i];
            do_run(n, $urandom_range(3, 0), r[0], -1);
        end

        repeat (4) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // global watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/vc_test_check_sink.md
VC_TEST_CHECK_SINK -- requirements
Module: vc_test_check_sink

Interface
REQ-001 Parameter SHALL be p_msg_nbits, default 1: message width in bits.
REQ-002 Parameter SHALL be p_num_msgs, default 1024: expected-message memory depth; c_idx_nbits = $clog2(p_num_msgs)+1.
REQ-003 Port SHALL be clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port SHALL be reset  input  1  synchronous, active-high reset.
REQ-005 Port SHALL be go  input  1  start-check pulse.
REQ-006 Port SHALL be num_msgs  input  c_idx_nbits  count of messages to check, latched on go.
REQ-007 Port SHALL be ld_en / ld_idx / ld_msg  input  1 / c_idx_nbits-1 / p_msg_nbits  expected-memory write port.
REQ-008 Port SHALL be in_val / in_rdy / in_msg  input / output / input  1 / 1 / p_msg_nbits  val/rdy input stream, fed from the random-delay stage.
REQ-009 Port SHALL be done  output  1  all num_msgs messages consumed.
REQ-010 Port SHALL be err_count  output  32  mismatch count.
REQ-011 Port SHALL be first_err_idx / first_err_got / first_err_exp  output  c_idx_nbits / p_msg_nbits / p_msg_nbits  first-mismatch record.
REQ-012 Port SHALL be extra_msg  output  1  sticky: in_val seen while in DONE.

Function
REQ-013 FSM SHALL have states IDLE, RUN, DONE.
REQ-014 IDLE: in_rdy=0, done=0; go with num_msgs==0 SHALL go to DONE; go with num_msgs>0 SHALL go to RUN.
REQ-015 On go (IDLE or DONE): latch min(num_msgs, p_num_msgs); clear idx, err_count, first_err_* and extra_msg.
REQ-016 ld_en SHALL write mem[ld_idx]<=ld_msg in IDLE and DONE, be ignored in RUN, and preserve contents across go.
REQ-017 RUN: in_rdy=1; fire = in_val && in_rdy; in_msg SHALL be compared in the fire cycle against combinationally-read mem[idx].
REQ-018 On fire: idx SHALL increment; on mismatch err_count SHALL increment, saturating at 32'hFFFF_FFFF.
REQ-019 First mismatch after go SHALL capture idx/in_msg/mem[idx] into first_err_*; later mismatches SHALL NOT overwrite it.
REQ-020 Fire at idx == latched count-1 SHALL move to DONE; done SHALL assert the next cycle (1-cycle latency after last fire).
REQ-021 In RUN, go SHALL be ignored; in_val low SHALL hold all state.
REQ-022 DONE: in_rdy=0, done=1; in_val=1 SHALL set extra_msg (sticky until go/reset); go SHALL restart per REQ-014/015.
REQ-023 Not-X checks SHALL fire on in_val, go, num_msgs whenever reset is low.

Reset
REQ-024 Reset SHALL force IDLE, idx=0, latched count=0, err_count=0, first_err_*=0, extra_msg=0, done=0, in_rdy=0 on the next edge, including mid-RUN.
REQ-025 Reset SHALL NOT clear the expected-message memory.

Structure
REQ-026 State encoding (2-bit IDLE=0, RUN=1, DONE=2) and the err_count saturation constant SHALL live in package vc_test_pkg.
REQ-027 idx and err_count SHALL use sub-module vc_EnResetReg; memory and FSM SHALL be inline.

Verification
REQ-028 Load mem {0..3}=8'h11,22,33,44; go, num_msgs=4; send same, in_val constantly 1 -> 4 fires, done=1 one cycle after 4th, err_count=0.
REQ-029 Same load, send 11,99,33,55 -> err_count=2, first_err_idx=1, first_err_got=8'h99, first_err_exp=8'h22.
REQ-030 go with num_msgs=0 -> DONE next cycle, done=1, in_rdy=0; in_val=1 then -> extra_msg=1.
REQ-031 Reset asserted after 2 of 4 fires -> IDLE, all outputs 0; go again -> checks from idx 0 against unchanged memory.
REQ-032 Upstream random delay max 5, 16 msgs, plus ld_en pulses during RUN -> err_count=0, done=1, memory unchanged by ignored writes.
